// File: rtl/spi_master_seq.sv
// SPI master sequencer (mode 0, MSB first): drives SCLK/SS_n/MOSI for one WIDTH-bit frame and captures MISO.
// Optional build macro SPI_LOOPBACK_EN adds a Loop input that feeds MOSI back into the receive shifter.
`timescale 1ns/1ps

module spi_master_seq #(
   parameter int WIDTH   = 32,
   parameter int MIN_DIV = 2,
   parameter int GAP_CYC = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [7:0]       ClockDiv,
   input  logic             Start,
   input  logic [WIDTH-1:0] DataIn,
`ifdef SPI_LOOPBACK_EN
   input  logic             Loop,
`endif
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] DataOut,
   output logic             SCLK,
   output logic             MOSI,
   input  logic             MISO,
   output logic             SS_n
);

   localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      HIGH  = 3'd2,
      LOW   = 3'd3,
      HOLD  = 3'd4,
      GAP   = 3'd5
   } state_t;

   state_t           state;
   logic [7:0]       half;
   logic [7:0]       hcnt;
   logic [BCW-1:0]   bit_cnt;
   logic             last_bit;
   logic [WIDTH-1:0] tx_sh;
   logic [WIDTH-1:0] rx_sh;
   logic             hcnt_end;
   logic             rx_bit;

   // Half-period saturates at MIN_DIV so the slave's SCLK synchroniser never misses an edge.
   function automatic logic [7:0] clamp_half(input logic [7:0] div);
      if (div < 8'(MIN_DIV))
         return 8'(MIN_DIV);
      else
         return div;
   endfunction

   assign hcnt_end = (hcnt == (half - 8'd1));

`ifdef SPI_LOOPBACK_EN
   logic loop_q;
   assign rx_bit = loop_q ? MOSI : MISO;
`else
   assign rx_bit = MISO;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         half     <= 8'd0;
         hcnt     <= 8'd0;
         bit_cnt  <= '0;
         last_bit <= 1'b0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         DataOut  <= '0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         SCLK     <= 1'b0;
         MOSI     <= 1'b0;
         SS_n     <= 1'b1;
`ifdef SPI_LOOPBACK_EN
         loop_q   <= 1'b0;
`endif
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  half     <= clamp_half(ClockDiv);
                  hcnt     <= 8'd0;
                  bit_cnt  <= '0;
                  last_bit <= 1'b0;
                  tx_sh    <= DataIn;
                  rx_sh    <= '0;
                  MOSI     <= DataIn[WIDTH-1];
                  SS_n     <= 1'b0;
                  Busy     <= 1'b1;
`ifdef SPI_LOOPBACK_EN
                  loop_q   <= Loop;
`endif
                  state    <= SETUP;
               end
            end

            SETUP: begin
               if (hcnt_end) begin
                  hcnt  <= 8'd0;
                  SCLK  <= 1'b1;
                  rx_sh <= {rx_sh[WIDTH-2:0], rx_bit};
                  state <= HIGH;
               end else begin
                  hcnt <= hcnt + 8'd1;
               end
            end

            HIGH: begin
               if (hcnt_end) begin
                  hcnt  <= 8'd0;
                  SCLK  <= 1'b0;
                  state <= LOW;
                  if (bit_cnt == BCW'(WIDTH - 1)) begin
                     last_bit <= 1'b1;
                  end else begin
                     // Rotating keeps the shifter's full width live; only bit WIDTH-2 is presented next.
                     bit_cnt <= bit_cnt + 1'b1;
                     tx_sh   <= {tx_sh[WIDTH-2:0], tx_sh[WIDTH-1]};
                     MOSI    <= tx_sh[WIDTH-2];
                  end
               end else begin
                  hcnt <= hcnt + 8'd1;
               end
            end

            LOW: begin
               if (hcnt_end) begin
                  hcnt <= 8'd0;
                  if (last_bit) begin
                     state <= HOLD;
                  end else begin
                     SCLK  <= 1'b1;
                     rx_sh <= {rx_sh[WIDTH-2:0], rx_bit};
                     state <= HIGH;
                  end
               end else begin
                  hcnt <= hcnt + 8'd1;
               end
            end

            HOLD: begin
               if (hcnt_end) begin
                  hcnt    <= 8'd0;
                  SS_n    <= 1'b1;
                  DataOut <= rx_sh;
                  Done    <= 1'b1;
                  state   <= GAP;
               end else begin
                  hcnt <= hcnt + 8'd1;
               end
            end

            GAP: begin
               if (hcnt == 8'(GAP_CYC - 1)) begin
                  hcnt  <= 8'd0;
                  Busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  hcnt <= hcnt + 8'd1;
               end
            end

            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
               SCLK  <= 1'b0;
               SS_n  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_seq.sv
// Directed bench for spi_master_seq with a behavioural mode-0 slave and frame-timing monitors.
`timescale 1ns/1ps

module tb_spi_master_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rstn;
   logic [7:0]   ClockDiv;
   logic         Start;
   logic [W-1:0] DataIn;
   logic         Busy;
   logic         Done;
   logic [W-1:0] DataOut;
   logic         SCLK;
   logic         MOSI;
   logic         MISO;
   logic         SS_n;
`ifdef SPI_LOOPBACK_EN
   logic         Loop;
`endif

   spi_master_seq #(.WIDTH(W), .MIN_DIV(2), .GAP_CYC(4)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .ClockDiv (ClockDiv),
      .Start    (Start),
      .DataIn   (DataIn),
`ifdef SPI_LOOPBACK_EN
      .Loop     (Loop),
`endif
      .Busy     (Busy),
      .Done     (Done),
      .DataOut  (DataOut),
      .SCLK     (SCLK),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .SS_n     (SS_n)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic         mon_clr;
   logic [W-1:0] sl_pre;
   logic [W-1:0] sl_sh;
   logic [W-1:0] sl_rx;
   logic [W-1:0] done_data [8];
   int           gaps [8];
   int           rises, done_cnt, fr_n, low_run, last_low, high_run, gap_n;
   int           busy_run, last_busy, busy_rises;
   logic         p_ssn, p_sclk, p_busy;

   // Slave model and frame monitors, sampled on the inactive clock edge.
   always @(negedge clk) begin
      if (mon_clr) begin
         sl_sh = '0; sl_rx = '0; MISO = 1'b0;
         rises = 0; done_cnt = 0; fr_n = 0; low_run = 0; last_low = 0;
         high_run = 0; gap_n = 0; busy_run = 0; last_busy = 0; busy_rises = 0;
         for (int i = 0; i < 8; i++) begin
            done_data[i] = '0;
            gaps[i] = 0;
         end
         p_ssn = SS_n; p_sclk = SCLK; p_busy = Busy;
      end else begin
         if (p_ssn && !SS_n) begin
            if (fr_n > 0 && gap_n < 8) begin
               gaps[gap_n] = high_run;
               gap_n++;
            end
            sl_sh = sl_pre + W'(fr_n);
            fr_n++;
            sl_rx = '0;
            MISO = sl_sh[W-1];
            low_run = 0;
         end
         if (!p_ssn && SS_n) begin
            last_low = low_run;
            high_run = 0;
         end
         if (SS_n) high_run++;
         else      low_run++;
         if (!p_sclk && SCLK) begin
            sl_rx = {sl_rx[W-2:0], MOSI};
            rises++;
         end
         if (p_sclk && !SCLK) begin
            sl_sh = {sl_sh[W-2:0], 1'b0};
            MISO = sl_sh[W-1];
         end
         if (!p_busy && Busy) begin
            busy_rises++;
            busy_run = 0;
         end
         if (Busy) busy_run++;
         if (p_busy && !Busy) last_busy = busy_run;
         if (Done) begin
            if (done_cnt < 8) done_data[done_cnt] = DataOut;
            done_cnt++;
         end
         p_ssn = SS_n; p_sclk = SCLK; p_busy = Busy;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      @(negedge clk) mon_clr = 1'b1;
      @(negedge clk);
      @(negedge clk) mon_clr = 1'b0;
   endtask

   task automatic start_frame(input logic [7:0] div, input logic [W-1:0] d);
      @(negedge clk);
      ClockDiv = div;
      DataIn   = d;
      Start    = 1'b1;
      @(negedge clk);
      Start    = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (Busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("idle_reached", 64'(Busy), 64'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      mon_clr  = 1'b1;
      sl_pre   = '0;
      rstn     = 1'b0;
      ClockDiv = 8'd0;
      Start    = 1'b0;
      DataIn   = '0;
`ifdef SPI_LOOPBACK_EN
      Loop     = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_ssn",  64'(SS_n),    64'd1);
      chk("rst_sclk", 64'(SCLK),    64'd0);
      chk("rst_mosi", 64'(MOSI),    64'd0);
      chk("rst_busy", 64'(Busy),    64'd0);
      chk("rst_done", 64'(Done),    64'd0);
      chk("rst_dout", 64'(DataOut), 64'd0);
      rstn = 1'b1;
      clear_mon();

      // Nominal frame, H=4
      sl_pre = 32'h12345678;
      start_frame(8'd4, 32'hA5A5F00F);
      wait_idle(1000);
      chk("t1_slave_rx", 64'(sl_rx),     64'hA5A5F00F);
      chk("t1_dout",     64'(DataOut),   64'h12345678);
      chk("t1_dones",    64'(done_cnt),  64'd1);
      chk("t1_ssn_low",  64'(last_low),  64'd264);
      chk("t1_rises",    64'(rises),     64'd32);
      chk("t1_busy_len", 64'(last_busy), 64'd268);

      // ClockDiv below minimum clamps to H=2
      clear_mon();
      sl_pre = 32'hCAFEBABE;
      start_frame(8'd0, 32'h0F1E2D3C);
      wait_idle(1000);
      chk("t2_slave_rx", 64'(sl_rx),     64'h0F1E2D3C);
      chk("t2_dout",     64'(DataOut),   64'hCAFEBABE);
      chk("t2_ssn_low",  64'(last_low),  64'd132);
      chk("t2_rises",    64'(rises),     64'd32);
      chk("t2_busy_len", 64'(last_busy), 64'd136);

      // Start pulses while busy are ignored
      clear_mon();
      sl_pre = 32'h2468ACE0;
      start_frame(8'd4, 32'h13579BDF);
      repeat (8) @(negedge clk);
      DataIn = 32'hFFFFFFFF;
      Start  = 1'b1;
      @(negedge clk) Start = 1'b0;
      repeat (100) @(negedge clk);
      Start = 1'b1;
      @(negedge clk) Start = 1'b0;
      wait_idle(1000);
      chk("t3_dones",      64'(done_cnt),   64'd1);
      chk("t3_busy_rises", 64'(busy_rises), 64'd1);
      chk("t3_dout",       64'(DataOut),    64'h2468ACE0);
      chk("t3_slave_rx",   64'(sl_rx),      64'h13579BDF);
      chk("t3_rises",      64'(rises),      64'd32);
      chk("t3_ssn_low",    64'(last_low),   64'd264);

      // Start held: three back-to-back frames, H=3
      clear_mon();
      sl_pre = 32'h0BADF00D;
      @(negedge clk);
      ClockDiv = 8'd3;
      DataIn   = 32'h89ABCDEF;
      Start    = 1'b1;
      n = 0;
      while (done_cnt < 3 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      Start = 1'b0;
      wait_idle(1000);
      chk("t4_dones",      64'(done_cnt),     64'd3);
      chk("t4_dout0",      64'(done_data[0]), 64'h0BADF00D);
      chk("t4_dout1",      64'(done_data[1]), 64'h0BADF00E);
      chk("t4_dout2",      64'(done_data[2]), 64'h0BADF00F);
      chk("t4_gap_n",      64'(gap_n),        64'd2);
      chk("t4_gap0",       64'(gaps[0]),      64'd5);
      chk("t4_gap1",       64'(gaps[1]),      64'd5);
      chk("t4_ssn_low",    64'(last_low),     64'd198);
      chk("t4_slave_rx",   64'(sl_rx),        64'h89ABCDEF);
      chk("t4_busy_rises", 64'(busy_rises),   64'd3);

      // Asynchronous reset mid-frame at bit 12
      clear_mon();
      sl_pre = 32'h55AA33CC;
      start_frame(8'd4, 32'h0F0F0F0F);
      n = 0;
      while (rises < 12 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("t5_reach_bit12", 64'(rises >= 12), 64'd1);
      rstn = 1'b0;
      #1;
      chk("t5_rst_ssn",  64'(SS_n),    64'd1);
      chk("t5_rst_sclk", 64'(SCLK),    64'd0);
      chk("t5_rst_busy", 64'(Busy),    64'd0);
      chk("t5_rst_dout", 64'(DataOut), 64'd0);
      chk("t5_rst_mosi", 64'(MOSI),    64'd0);
      @(negedge clk);
      chk("t5_no_done",  64'(done_cnt), 64'd0);
      rstn = 1'b1;
      clear_mon();
      sl_pre = 32'h600DCAFE;
      start_frame(8'd4, 32'h3C3CA5A5);
      wait_idle(1000);
      chk("t5_dout",     64'(DataOut),  64'h600DCAFE);
      chk("t5_slave_rx", 64'(sl_rx),    64'h3C3CA5A5);
      chk("t5_rises",    64'(rises),    64'd32);
      chk("t5_dones",    64'(done_cnt), 64'd1);
      chk("t5_ssn_low",  64'(last_low), 64'd264);

`ifdef SPI_LOOPBACK_EN
      // Loopback: MISO held at 0 by the slave preload
      clear_mon();
      sl_pre = 32'h0;
      Loop = 1'b1;
      start_frame(8'd4, 32'hDEADBEEF);
      wait_idle(1000);
      chk("t6_loop_dout",  64'(DataOut), 64'hDEADBEEF);
      chk("t6_loop_rises", 64'(rises),   64'd32);
      clear_mon();
      Loop = 1'b0;
      start_frame(8'd4, 32'hDEADBEEF);
      wait_idle(1000);
      chk("t6_noloop_dout", 64'(DataOut), 64'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_master_seq.md
Name: spi_master_seq

Overview:
- SPI master sequencer that generates SCLK, SS_n and MOSI to drive one fixed-width frame into the team's SPI slave block, and captures MISO at the same time.
- Mode 0 compatible with the slave: MSB first, slave samples MOSI on SCLK rise, slave shifts MISO on SCLK fall.
- Sits on the controller side of the link. Software or an FSM loads a word, pulses Start, waits for Done/Busy low and reads the received word.

Parameters:
- WIDTH, 32, frame length in bits; must match slave shift-register width.
- MIN_DIV, 2, minimum SCLK half-period in clk cycles; guarantees the slave's 2-flop SCLK synchroniser sees every edge.
- GAP_CYC, 4, clk cycles SS_n stays high after a frame before a new Start is accepted (≥1).

Ports:
- clk  input  1  system clock; single clock domain.
- rstn  input  1  asynchronous active-low reset.
- ClockDiv  input  8  requested SCLK half-period in clk cycles; sampled on Start accept.
- Start  input  1  level request; accepted only in IDLE.
- DataIn  input  WIDTH  word to transmit; sampled on Start accept.
- Busy  output  1  high from the cycle after accept through the end of GAP.
- Done  output  1  one-cycle pulse when DataOut is updated.
- DataOut  output  WIDTH  last received word; holds until the next Done.
- SCLK  output  1  serial clock; idles low.
- MOSI  output  1  serial data out.
- MISO  input  1  serial data in.
- SS_n  output  1  active-low slave select; idles high.

Behaviour:
- Reset values (async, on rstn low, including mid-frame): SS_n=1, SCLK=0, MOSI=0, Busy=0, Done=0, DataOut=0, state=IDLE, all counters=0. No partial frame resumes after reset.
- Half-period H = max(ClockDiv, MIN_DIV), latched at accept. ClockDiv changes mid-frame have no effect.
- States: IDLE -> SETUP -> HIGH <-> LOW -> HOLD -> GAP -> IDLE.
- IDLE: on Start=1, next cycle: tx shift register <= DataIn, MOSI=DataIn[WIDTH-1], SS_n=0, Busy=1, bit counter=0, state SETUP.
- SETUP: SCLK=0 for H cycles, then go to HIGH.
- HIGH: on entry, SCLK=1 and MISO is shifted into the rx register LSB (rx <= {rx[WIDTH-2:0], MISO}). Stay H cycles, then go to LOW.
- LOW: on entry, SCLK=0.
  - If bit counter < WIDTH-1: MOSI advances to the next bit and the counter increments.
  - Otherwise the next state after H cycles is HOLD.
  - LOW lasts H cycles, then goes to HIGH or HOLD.
- HOLD: SCLK=0, MOSI unchanged, for H cycles. On exit: SS_n=1, DataOut <= rx, Done=1 for exactly that cycle, state GAP.
- GAP: SS_n=1 for GAP_CYC cycles. Busy drops on the cycle the FSM returns to IDLE.
- Timing:
  - SS_n low time is exactly 2·H·(WIDTH+1) clk cycles.
  - Exactly WIDTH rising SCLK edges occur per frame.
  - Busy high time is 2·H·(WIDTH+1)+GAP_CYC cycles.
- Start while Busy=1 is ignored; no queuing.
- Start held continuously gives back-to-back frames separated by GAP_CYC+1 cycles of SS_n high.
- SCLK, MOSI and SS_n are registered outputs; no combinational path from inputs to outputs.
- Counters: half-period counter is 8 bits; bit counter is clog2(WIDTH) bits. No wrap occurs in legal operation.

Optional Feature:
- Macro SPI_LOOPBACK_EN.
- When defined:
  - Adds input port Loop (1 bit), sampled at Start accept.
  - With Loop=1, the rx shift takes MOSI (the registered output value) instead of MISO, so DataOut == DataIn after Done. SCLK and SS_n still toggle normally.
- When undefined: port Loop is absent and rx always shifts MISO.

Test Plan:
- ClockDiv=4, DataIn=32'hA5A5F00F, slave model preloaded 32'h12345678 -> slave receives A5A5F00F; master DataOut=12345678 with one Done pulse; SS_n low 264 cycles; 32 SCLK rises.
- ClockDiv=0 -> H clamps to 2; SS_n low 132 cycles; data still correct both directions.
- Start pulsed again 10 cycles after accept and mid-frame -> ignored; a single frame, Busy continuous, one Done.
- Start held high for three frames with ClockDiv=3 -> three frames; SS_n high gap of GAP_CYC+1=5 cycles between them; DataOut updated three times.
- rstn driven low at bit 12 -> SS_n=1, SCLK=0, Busy=0, DataOut=0 immediately. After release, a new Start runs a complete correct frame.
- SPI_LOOPBACK_EN defined, Loop=1, DataIn=32'hDEADBEEF, MISO tied 0 -> DataOut=DEADBEEF. With Loop=0 -> DataOut=0.
